uart_rx_cmd: RTL

- UART 8N1 receiver plus command-packet decoder. It is the receive-side counterpart of the design's RS-232 transmit path.
- A host PC sends fixed-length command packets: header, command ID, 16-bit argument, XOR checksum. The block validates each packet and presents the command as a one-cycle strobe with held fields.
- It sits beside the UART transmitter in the top level and drives runtime control of the image pipeline, e.g. binarisation threshold and selector mode.

---
 rtl/uart_rx_cmd.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/uart_rx_cmd.sv
// uart_rx_cmd: 8N1 UART receiver with header/cmd/arg/XOR-checksum packet decoder.
module uart_rx_cmd #(
    parameter int          CLK_FREQ     = 50000000,
    parameter int          BAUD         = 115200,
    parameter int          CLKS_PER_BIT = CLK_FREQ / BAUD,
    parameter logic [7:0]  HEADER       = 8'hAA,
    parameter int          TIMEOUT_BITS = 20
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rs232_rx,
    output logic [7:0]  rx_byte,
    output logic        rx_byte_valid,
    output logic [7:0]  cmd_id,
    output logic [15:0] cmd_data,
    output logic        cmd_valid,
    output logic        frame_err,
    output logic        chk_err,
    output logic        to_err
);
    localparam int CW     = $clog2(CLKS_PER_BIT);
    localparam int TO_LIM = TIMEOUT_BITS * CLKS_PER_BIT;
    localparam int GW     = $clog2(TO_LIM + 1);
    localparam logic [CW-1:0] HALF = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] FULL = CW'(CLKS_PER_BIT - 1);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} bit_t;
    typedef enum logic [2:0] {P_HDR, P_CMD, P_DHI, P_DLO, P_CHK} pkt_t;

    bit_t        bst_q, bst_d;
    pkt_t        pst_q, pst_d;
    logic [2:0]  sync_q, sync_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]  idx_q, idx_d;
    logic [7:0]  sr_q, sr_d, cmd_b_q, cmd_b_d, dhi_q, dhi_d, dlo_q, dlo_d;
    logic [GW-1:0] gap_q, gap_d;
    logic [7:0]  rx_byte_q, rx_byte_d, cmd_id_q, cmd_id_d;
    logic [15:0] cmd_data_q, cmd_data_d;
    logic        rbv_q, rbv_d, cv_q, cv_d, fe_q, fe_d, ce_q, ce_d, te_q, te_d;
    logic        line, zero, byte_done, stop_bad, to_fire, byte_ok, good;

    always_comb begin
        sync_d     = {sync_q[1:0], rs232_rx};
        line       = sync_q[1];
        zero       = cnt_q == '0;
        bst_d      = bst_q;
        cnt_d      = cnt_q - CW'(1);
        idx_d      = idx_q;
        sr_d       = sr_q;
        byte_done  = 1'b0;
        stop_bad   = 1'b0;
        case (bst_q)
            IDLE:  if (sync_q[2] && !sync_q[1]) begin
                       bst_d = START;
                       cnt_d = HALF;
                   end
            START: if (zero) begin
                       bst_d = line ? IDLE : DATA;
                       cnt_d = FULL;
                       idx_d = '0;
                   end
            DATA:  if (zero) begin
                       sr_d  = {line, sr_q[7:1]};
                       idx_d = idx_q + 3'd1;
                       cnt_d = FULL;
                       bst_d = idx_q == 3'd7 ? STOP : DATA;
                   end
            STOP:  if (zero) begin
                       bst_d     = IDLE;
                       byte_done = line;
                       stop_bad  = !line;
                   end
            default: bst_d = IDLE;
        endcase
        // a timeout outranks any byte or framing event landing in the same cycle
        to_fire    = pst_q != P_HDR && gap_q == GW'(TO_LIM - 1);
        byte_ok    = byte_done && !to_fire;
        gap_d      = (byte_done || pst_q == P_HDR || to_fire) ? '0 : gap_q + GW'(1);
        rbv_d      = byte_done;
        rx_byte_d  = byte_done ? sr_q : rx_byte_q;
        fe_d       = stop_bad && !to_fire;
        te_d       = to_fire;
        good       = sr_q == (cmd_b_q ^ dhi_q ^ dlo_q);
        cv_d       = byte_ok && pst_q == P_CHK && good;
        ce_d       = byte_ok && pst_q == P_CHK && !good;
        cmd_id_d   = cv_d ? cmd_b_q : cmd_id_q;
        cmd_data_d = cv_d ? {dhi_q, dlo_q} : cmd_data_q;
        cmd_b_d    = byte_ok && pst_q == P_CMD ? sr_q : cmd_b_q;
        dhi_d      = byte_ok && pst_q == P_DHI ? sr_q : dhi_q;
        dlo_d      = byte_ok && pst_q == P_DLO ? sr_q : dlo_q;
        pst_d      = pst_q;
        if (to_fire || stop_bad)
            pst_d = P_HDR;
        else if (byte_ok)
            case (pst_q)
                P_HDR:   pst_d = sr_q == HEADER ? P_CMD : P_HDR;
                P_CMD:   pst_d = P_DHI;
                P_DHI:   pst_d = P_DLO;
                P_DLO:   pst_d = P_CHK;
                default: pst_d = P_HDR;
            endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q     <= 3'b111;
            bst_q      <= IDLE;
            pst_q      <= P_HDR;
            cnt_q      <= '0;
            idx_q      <= '0;
            sr_q       <= '0;
            cmd_b_q    <= '0;
            dhi_q      <= '0;
            dlo_q      <= '0;
            gap_q      <= '0;
            rx_byte_q  <= '0;
            cmd_id_q   <= '0;
            cmd_data_q <= '0;
            rbv_q      <= 1'b0;
            cv_q       <= 1'b0;
            fe_q       <= 1'b0;
            ce_q       <= 1'b0;
            te_q       <= 1'b0;
        end else begin
            sync_q     <= sync_d;
            bst_q      <= bst_d;
            pst_q      <= pst_d;
            cnt_q      <= cnt_d;
            idx_q      <= idx_d;
            sr_q       <= sr_d;
            cmd_b_q    <= cmd_b_d;
            dhi_q      <= dhi_d;
            dlo_q      <= dlo_d;
            gap_q      <= gap_d;
            rx_byte_q  <= rx_byte_d;
            cmd_id_q   <= cmd_id_d;
            cmd_data_q <= cmd_data_d;
            rbv_q      <= rbv_d;
            cv_q       <= cv_d;
            fe_q       <= fe_d;
            ce_q       <= ce_d;
            te_q       <= te_d;
        end
    end

    assign rx_byte       = rx_byte_q;
    assign rx_byte_valid = rbv_q;
    assign cmd_id        = cmd_id_q;
    assign cmd_data      = cmd_data_q;
    assign cmd_valid     = cv_q;
    assign frame_err     = fe_q;
    assign chk_err       = ce_q;
    assign to_err        = te_q;
endmodule
